// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// funct3 op codes, FSM state encodings and default widths.
package mdu_unit_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 4;
    localparam int CNT_W_DEF = 6;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient
// bit per enabled cycle; done_o flags the cycle of the last step.
module mdu_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            done_o
);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dsr_q;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;

    // Partial remainder stays below the divisor, so an XLEN+1 bit
    // subtract is enough for its sign bit to mean "did not fit".
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dsr_q};
        quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(XLEN - 1));
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else if (en_i) begin
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dsr_q  <= divisor_i;
            end else if (busy_q) begin
                quo_q <= quo_d;
                rem_q <= rem_d;
                cnt_q <= cnt_q + 1'b1;
                if (done_o)
                    busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// RV32M execution unit: 2-cycle multiply, XLEN+2 cycle divide.
// MDU_DIV_EARLY_OUT_EN: divide-by-zero/overflow skip the divider.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_val,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   rs1_q, rs2_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2*XLEN-1:0] prod_q;
    logic              dz_q, ovf_q;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_val_q, out_val_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    logic                 accept;
    logic                 s1_in, s2_in, dsg_in;
    logic                 dz_in, ovf_in, early;
    logic signed [XLEN:0] ma, mb;
    logic signed [2*XLEN+1:0] mfull;
    logic [XLEN-1:0]      dvd_mag, dsr_mag;
    logic                 div_start, div_done;
    logic [XLEN-1:0]      div_quo, div_rem;
    logic                 dsg_q, qneg, rneg;
    logic [XLEN-1:0]      q_fix, r_fix, fix_res;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready && ready && !flush;

    assign s1_in  = (in_op == MDU_MULH) || (in_op == MDU_MULHSU);
    assign s2_in  = (in_op == MDU_MULH);
    assign dsg_in = in_op[2] && !in_op[0];

    assign ma    = {s1_in & in_rs1[XLEN-1], in_rs1};
    assign mb    = {s2_in & in_rs2[XLEN-1], in_rs2};
    assign mfull = (2*XLEN+2)'(ma) * (2*XLEN+2)'(mb);

    assign dz_in  = (in_rs2 == '0);
    assign ovf_in = dsg_in && (in_rs1 == MIN_NEG) && (&in_rs2);

`ifdef MDU_DIV_EARLY_OUT_EN
    assign early = dz_in || ovf_in;
`else
    assign early = 1'b0;
`endif

    assign dvd_mag   = (dsg_in && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
    assign dsr_mag   = (dsg_in && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
    assign div_start = accept && in_op[2] && !early;

    mdu_divider #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .en_i       (ready),
        .clear_i    (flush),
        .start_i    (div_start),
        .dividend_i (dvd_mag),
        .divisor_i  (dsr_mag),
        .quo_o      (div_quo),
        .rem_o      (div_rem),
        .done_o     (div_done)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= in_op;
            rs1_q  <= in_rs1;
            rs2_q  <= in_rs2;
            tag_q  <= in_tag;
            prod_q <= mfull[2*XLEN-1:0];
            dz_q   <= dz_in;
            ovf_q  <= ovf_in;
        end
    end

    // Special cases override whatever the divider left behind.
    always_comb begin
        dsg_q = !op_q[0];
        qneg  = dsg_q && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
        rneg  = dsg_q && rs1_q[XLEN-1];
        q_fix = qneg ? -div_quo : div_quo;
        r_fix = rneg ? -div_rem : div_rem;
        if (dz_q) begin
            q_fix = '1;
            r_fix = rs1_q;
        end else if (ovf_q) begin
            q_fix = rs1_q;
            r_fix = '0;
        end
        fix_res = op_q[1] ? r_fix : q_fix;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_val_d   = out_val_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (ready) begin
            out_valid_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!in_op[2])
                            state_d = ST_MUL;
                        else
                            state_d = early ? ST_FIX : ST_DIV;
                    end
                end
                ST_MUL: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_tag_d   = tag_q;
                    out_val_d   = (op_q == MDU_MUL) ?
                                  prod_q[XLEN-1:0] :
                                  prod_q[2*XLEN-1:XLEN];
                end
                ST_DIV: begin
                    if (div_done)
                        state_d = ST_FIX;
                end
                ST_FIX: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    out_tag_d   = tag_q;
                    out_val_d   = fix_res;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_val_q   <= out_val_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign out_tag   = out_tag_q;

endmodule
